mul_issue_unit: RTL and testbench

//  EX-stage front end for the pipelined unsigned multiplier controller.
//  - Decodes MULT/MULTU from the EX stage.
//  - Converts signed operands to magnitudes and computes the result-negate flag.
//  - Issues a single-cycle start pulse and holds the EX stage until the result returns.
//  - Writes the 64-bit product into HI/LO.
//  - Drains an in-flight multiply after a pipeline flush.
//  - Flags a hung multiplier with a watchdog.

---
 rtl/mul_issue_unit.sv | 184 ++++++++++++++++++
 tb/tb_mul_issue_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_unit.sv
// EX-stage issue logic for the pipelined multiplier: decodes MULT/MULTU, issues
// operand magnitudes with a start pulse, stalls EX until the product returns, then writes HI/LO.
module mul_issue_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [1:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        mul_begin,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_res,
  input  logic        mul_done,
  output logic        stall_ex,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_WB    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int unsigned     WD_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
    logic [31:0] m;
    if (signed_op && v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t          state_r, next_state_s;
  logic [WD_W-1:0] wd_cnt_r;
  logic            mul_begin_r, mul_sign_r, hilo_we_r, err_r;
  logic [31:0]     mul_a_r, mul_b_r, hi_r, lo_r;

  logic is_mul_s, is_signed_s, wd_expire_s;
  logic accept_s, capture_s, err_set_s, stall_s, wd_run_s;

  assign is_mul_s    = ex_valid & ((ex_op == 2'b01) | (ex_op == 2'b10)) & ~flush;
  assign is_signed_s = (ex_op == 2'b01);
  assign wd_expire_s = (wd_cnt_r == WD_LAST);

  // Next-state decode and the combinational stall/accept/capture controls.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    err_set_s    = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (is_mul_s) begin
          stall_s      = 1'b1;
          accept_s     = 1'b1;
          next_state_s = S_BUSY;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_s = 1'b1;
        if (flush) begin
          // A result arriving with the flush dies with it; nothing left to drain.
          next_state_s = mul_done ? S_IDLE : S_DRAIN;
        end else if (mul_done) begin
          capture_s    = 1'b1;
          next_state_s = S_WB;
        end else if (wd_expire_s) begin
          err_set_s    = 1'b1;
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_BUSY;
        end
      end
      S_WB: begin
        next_state_s = S_IDLE;
      end
      S_DRAIN: begin
        stall_s = is_mul_s;
        if (mul_done) begin
          next_state_s = S_IDLE;
        end else if (wd_expire_s) begin
          err_set_s    = 1'b1;
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_DRAIN;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // The watchdog keeps counting across BUSY->DRAIN: it is the same multiply.
  always_comb begin
    if ((next_state_s == S_BUSY) || (next_state_s == S_DRAIN)) begin
      wd_run_s = (state_r == S_BUSY) || (state_r == S_DRAIN);
    end else begin
      wd_run_s = 1'b0;
    end
  end

  // State register and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      wd_cnt_r <= WD_ZERO;
    end else begin
      state_r  <= next_state_s;
      wd_cnt_r <= wd_run_s ? (wd_cnt_r + WD_ONE) : WD_ZERO;
    end
  end

  // Operand issue registers; held from accept until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_begin_r <= 1'b0;
      mul_sign_r  <= 1'b0;
      mul_a_r     <= 32'd0;
      mul_b_r     <= 32'd0;
    end else begin
      mul_begin_r <= accept_s;
      if (accept_s) begin
        mul_a_r    <= magnitude(ex_rs, is_signed_s);
        mul_b_r    <= magnitude(ex_rt, is_signed_s);
        mul_sign_r <= is_signed_s & (ex_rs[31] ^ ex_rt[31]);
      end else begin
        mul_a_r    <= mul_a_r;
        mul_b_r    <= mul_b_r;
        mul_sign_r <= mul_sign_r;
      end
    end
  end

  // Result capture for the HI/LO write and the watchdog strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_we_r <= 1'b0;
      err_r     <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      hilo_we_r <= capture_s;
      err_r     <= err_set_s;
      if (capture_s) begin
        hi_r <= mul_res[63:32];
        lo_r <= mul_res[31:0];
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end
  end

  assign mul_begin = mul_begin_r;
  assign mul_sign  = mul_sign_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign stall_ex  = stall_s;
  assign hilo_we   = hilo_we_r;
  assign hi_wdata  = hi_r;
  assign lo_wdata  = lo_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit with a 6-cycle stub multiplier and an HI/LO scoreboard.
module tb_mul_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_op = 2'b00;
  logic [31:0] ex_rs = 32'd0;
  logic [31:0] ex_rt = 32'd0;
  logic        flush = 1'b0;
  logic        mul_begin, mul_sign, stall_ex, hilo_we, err, mul_done;
  logic [31:0] mul_a, mul_b, hi_wdata, lo_wdata;
  logic [63:0] mul_res;

  mul_issue_unit #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush),
    .mul_begin(mul_begin), .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res(mul_res), .mul_done(mul_done), .stall_ex(stall_ex),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub multiplier: latches magnitudes on the start pulse, answers 6 cycles later.
  logic        stub_hang = 1'b0;
  logic        spur_done = 1'b0;
  logic [63:0] spur_res  = 64'd0;
  logic        sb_busy;
  int          sb_cnt;
  logic [63:0] sb_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy <= 1'b0;
      sb_cnt  <= 0;
      sb_res  <= 64'd0;
    end else if (sb_busy) begin
      if (sb_cnt == 6) sb_busy <= 1'b0;
      sb_cnt <= sb_cnt + 1;
    end else if (mul_begin && !stub_hang) begin
      sb_busy <= 1'b1;
      sb_cnt  <= 1;
      sb_res  <= mul_sign ? (64'd0 - ({32'd0, mul_a} * {32'd0, mul_b}))
                          : ({32'd0, mul_a} * {32'd0, mul_b});
    end
  end

  assign mul_done = (sb_busy && sb_cnt == 6) || spur_done;
  assign mul_res  = spur_done ? spur_res
                  : ((sb_busy && sb_cnt == 6) ? sb_res : 64'hDEAD_BEEF_DEAD_BEEF);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          hilo_cnt = 0, begin_cnt = 0, err_cnt = 0;
  int          begin_cyc = 0, done_cyc = 0;
  logic [31:0] last_a = 32'd0, last_b = 32'd0;
  logic        last_sign = 1'b0;

  // Output monitor: pops the scoreboard on every HI/LO write.
  always @(negedge clk) begin
    if (hilo_we) begin
      hilo_cnt++;
      check("hilo_we_expected", {159'd0, exp_q.size() != 0}, 160'd1);
      if (exp_q.size() != 0) check("hilo_data", {96'd0, hi_wdata, lo_wdata}, {96'd0, exp_q.pop_front()});
    end
    if (mul_begin) begin
      begin_cnt++;
      begin_cyc = cyc;
      last_a    = mul_a;
      last_b    = mul_b;
      last_sign = mul_sign;
    end
    if (mul_done) done_cyc = cyc;
    if (err) err_cnt++;
  end

  // Holds an op in EX until the stall releases; call #1 after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int stalls);
    ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt; stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall_ex) break;
      stalls++;
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = 2'b00;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic signed [63:0] s;
    if (op == 2'b01) begin
      s = 64'(signed'(rs)) * 64'(signed'(rt));
      return s;
    end
    return {32'd0, rs} * {32'd0, rt};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st, b0, h0, e0;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    #2;
    check("reset_outputs", {mul_begin, mul_sign, stall_ex, hilo_we, err, mul_a, mul_b, hi_wdata, lo_wdata},
          160'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: MULT -3 x 7
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    b0 = begin_cnt;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, st);
    check("t1_stall_cycles", 160'(st), 160'd8);
    check("t1_mag_sign", {95'd0, last_sign, last_a, last_b}, {95'd0, 1'b1, 32'd3, 32'd7});
    check("t1_one_begin", 160'(begin_cnt - b0), 160'd1);
    check("t1_done_to_begin", 160'(done_cyc - begin_cyc), 160'd6);

    // 2: MULTU FFFFFFFF x FFFFFFFF
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    check("t2_sign", {159'd0, last_sign}, 160'd0);
    check("t2_stall_cycles", 160'(st), 160'd8);

    // 3: MULT most-negative squared, then zero times negative
    exp_q.push_back(64'h4000_0000_0000_0000);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, st);
    check("t3_mag_sign", {95'd0, last_sign, last_a, last_b}, {95'd0, 1'b0, 32'h8000_0000, 32'h8000_0000});
    exp_q.push_back(64'd0);
    run_op(2'b01, 32'd0, 32'hFFFF_FFFB, st);
    check("t3_zero_mag_sign", {95'd0, last_sign, last_a, last_b}, {95'd0, 1'b1, 32'd0, 32'd5});

    // Reserved op and stray mul_done in IDLE do nothing
    b0 = begin_cnt; h0 = hilo_cnt;
    ex_valid = 1'b1; ex_op = 2'b11; ex_rs = 32'd9; ex_rt = 32'd9;
    @(negedge clk);
    check("reserved_no_stall", {159'd0, stall_ex}, 160'd0);
    spur_done = 1'b1; spur_res = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1;
    spur_done = 1'b0; ex_valid = 1'b0; ex_op = 2'b00;
    repeat (2) @(posedge clk); #1;
    check("reserved_no_begin", 160'(begin_cnt - b0), 160'd0);
    check("idle_done_ignored", 160'(hilo_cnt - h0), 160'd0);

    // 4: flush on the second BUSY cycle, MULTU 2x3 waits for the drained result
    ex_valid = 1'b1; ex_op = 2'b10; ex_rs = 32'd5; ex_rt = 32'd7;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = 2'b00;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b0 = begin_cnt;
    exp_q.push_back(64'd6);
    ex_valid = 1'b1; ex_op = 2'b10; ex_rs = 32'd2; ex_rt = 32'd3;
    @(negedge clk);
    check("t4_drain_stall", {159'd0, stall_ex}, 160'd1);
    check("t4_drain_no_begin", {159'd0, mul_begin}, 160'd0);
    @(posedge clk); #1;
    run_op(2'b10, 32'd2, 32'd3, st);
    check("t4_stall_cycles", 160'(st + 1), 160'd13);
    check("t4_one_begin", 160'(begin_cnt - b0), 160'd1);

    // 5: reset during BUSY
    h0 = hilo_cnt;
    ex_valid = 1'b1; ex_op = 2'b01; ex_rs = 32'hFFFF_FFF0; ex_rt = 32'd3;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = 2'b00;
    #1;
    check("t5_reset_outputs", {mul_begin, mul_sign, stall_ex, hilo_we, err, mul_a, mul_b, hi_wdata, lo_wdata},
          160'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("t5_no_write", 160'(hilo_cnt - h0), 160'd0);
    ra = 32'hFFFF_FFF9; rb = 32'd100;
    exp_q.push_back(model(2'b01, ra, rb));
    run_op(2'b01, ra, rb, st);
    check("t5_after_reset_stall", 160'(st), 160'd8);

    // A few random operations against the signed/unsigned product model
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom; ro = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_q.push_back(model(ro, ra, rb));
      run_op(ro, ra, rb, st);
      check("rand_stall", 160'(st), 160'd8);
    end

    // 6: hung multiplier trips the watchdog
    stub_hang = 1'b1;
    h0 = hilo_cnt; e0 = err_cnt; st = 0;
    ex_valid = 1'b1; ex_op = 2'b01; ex_rs = 32'd4; ex_rt = 32'd4;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err) break;
      st++;
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; ex_op = 2'b00;
    #1;
    check("t6_err_after_busy", 160'(st), 160'd16);
    check("t6_err_seen", {159'd0, err}, 160'd1);
    check("t6_stall_dropped", {159'd0, stall_ex}, 160'd0);
    @(negedge clk);
    check("t6_err_one_cycle", {159'd0, err}, 160'd0);
    check("t6_no_write", 160'(hilo_cnt - h0), 160'd0);
    stub_hang = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("err_pulse_count", 160'(err_cnt - e0), 160'd1);
    check("scoreboard_empty", 160'(exp_q.size()), 160'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
